// File: rtl/seq_addsub_pkg.sv
// Shared types and helpers for the multi-cycle add/subtract unit.
package seq_addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  typedef struct packed {
    logic s;
    logic co;
  } fa_out_t;

  // Single-bit full-adder cell; the ripple chunk is built from these.
  function automatic fa_out_t full_add(input logic a, input logic b, input logic ci);
    fa_out_t r;
    r.s  = a ^ b ^ ci;
    r.co = (a & b) | (ci & (a ^ b));
    return r;
  endfunction

endpackage

// File: rtl/seq_addsub_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder. Also exposes the carry into
// the MSB so the caller can derive signed overflow on the last chunk.
module rca_chunk
  import seq_addsub_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             Cin,
  output logic [CHUNK-1:0] S,
  output logic             Cout,
  output logic             Cmsb
);

  // Ripple the carry through the full-adder cells, LSB first.
  always_comb begin
    logic    c;
    fa_out_t r;
    c    = Cin;
    S    = '0;
    Cmsb = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) Cmsb = c;
      r    = full_add(A[i], B[i], c);
      S[i] = r.s;
      c    = r.co;
    end
    Cout = c;
  end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract: one CHUNK-wide slice per clock, LSB first,
// carry held in a register between slices. Result, Cout and V hold until
// the next accepted start.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding chunk idx_q each cycle
// DONE  | result complete, done pulse; start here chains the next op
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("seq_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  addsub_state_t    state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             zv_q, zv_d;   // result complete, so Z may reflect S

  logic [CHUNK-1:0] sum_chunk;
  logic             c_out, c_msb;

  rca_chunk #(.CHUNK(CHUNK)) u_rca (
    .A    (a_q[idx_q*CHUNK +: CHUNK]),
    .B    (b_q[idx_q*CHUNK +: CHUNK]),
    .Cin  (carry_q),
    .S    (sum_chunk),
    .Cout (c_out),
    .Cmsb (c_msb)
  );

  // Next-state logic: accept operands, step through chunks, capture flags.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    zv_d    = zv_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? 1'b1 : Cin;
          idx_d   = '0;
          s_d     = '0;
          zv_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d[idx_q*CHUNK +: CHUNK] = sum_chunk;
        carry_d = c_out;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = c_out;
          v_d     = c_msb ^ c_out;
          zv_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      zv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      zv_q    <= zv_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;
  assign V    = v_q;
  assign Z    = zv_q & ~|s_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub at WIDTH=32, CHUNK=8 (4 cycles per op).
module tb_seq_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        sub = 1'b0;
  logic        Cin = 1'b0;
  logic        busy, done, Cout, V, Z;
  logic [31:0] S;

  int n_tests = 0;
  int n_fail  = 0;

  seq_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .sub(sub), .Cin(Cin),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .V(V), .Z(Z)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called mid-cycle; returns #1 after the accepting edge with junk on the inputs.
  task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic c);
    A = a; B = b; sub = s; Cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'hCAFE_F00D; sub = ~s; Cin = ~c;
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
  endtask

  // Returns #1 after the edge that raises done.
  task automatic wait_done(input string tag);
    int lat = 0;
    int busy_cyc = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cyc++;
    end
    chk({tag, "_latency"}, lat, 32'd4);
    chk({tag, "_busy_cycles"}, busy_cyc, 32'd4);
  endtask

  task automatic check_res(input string tag, input logic [31:0] s, input logic c,
                           input logic v, input logic z);
    chk({tag, "_S"}, S, s);
    chk({tag, "_Cout"}, {31'd0, Cout}, {31'd0, c});
    chk({tag, "_V"}, {31'd0, V}, {31'd0, v});
    chk({tag, "_Z"}, {31'd0, Z}, {31'd0, z});
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c, input logic [31:0] es,
                        input logic ec, input logic ev, input logic ez);
    @(posedge clk); #1;
    start_op(tag, a, b, s, c);
    wait_done(tag);
    check_res(tag, es, ec, ev, ez);
  endtask

  initial begin
    int pulses;
    logic [31:0] s_at;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    check_res("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    run_op("ripple",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("ovf_add",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("borrow",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("add_cin",  32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
    run_op("sub_cin",  32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 32'h0123_4567, 1'b1, 1'b0, 1'b0);

    // Start while busy is ignored; exactly one done pulse.
    @(posedge clk); #1;
    start_op("ign", 32'd1, 32'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    A = 32'd9; B = 32'd9; sub = 1'b0; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    s_at = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      if (done) begin pulses++; s_at = S; end
      @(posedge clk); #1;
    end
    chk("ign_pulses", pulses, 32'd1);
    chk("ign_S_at_done", s_at, 32'd2);
    chk("ign_S_hold", S, 32'd2);

    // Back-to-back: start held in the DONE cycle chains the next op.
    run_op("b2b_first", 32'h11, 32'h22, 1'b0, 1'b0, 32'h33, 1'b0, 1'b0, 1'b0);
    start_op("b2b", 32'd3, 32'd4, 1'b0, 1'b0);
    wait_done("b2b");
    check_res("b2b", 32'd7, 1'b0, 1'b0, 1'b0);

    // Set Cout and V before the reset test so clearing is observable.
    run_op("ovf_cout", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Async reset after two chunks, away from any clock edge.
    @(posedge clk); #1;
    start_op("rst_mid", 32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_partial_S", S, 32'h0000_0202);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    check_res("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("rst_mid_no_done", pulses, 32'd0);

    run_op("after_rst", 32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
